// File: rtl/pagerank_weight_gen.sv
// Out-degree and reciprocal-weight generator for the PageRank iteration core.
// Define PAGERANK_SELF_LOOP_MASK_EN to exclude diagonal (self-loop) edges from the out-degree.
module pagerank_weight_gen #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*N-1:0]     adjacency,
  output logic [N*WIDTH-1:0] weights,
  output logic [N-1:0]       dangling,
  output logic               busy,
  output logic               done,
  output logic               weights_valid
);

  localparam int DEG_W = $clog2(N + 1);
  localparam int REM_W = WIDTH + DEG_W + 1;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int IT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEG,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [N*N-1:0]   adj_copy;
  logic [K_W-1:0]   k_idx;
  logic [IT_W-1:0]  iter;
  logic [DEG_W-1:0] divisor;
  logic [DEG_W-1:0] deg;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] dsh;
  logic [REM_W-1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] quot_final;
  logic [WIDTH-1:0] weight_k;
  logic             last_iter;
  logic             last_node;
  logic [WIDTH-1:0] w_arr [N];

  // Out-degree of node k: popcount of column k of the captured matrix.
  always_comb begin
    logic [IDX_W-1:0] bit_idx;
    deg = '0;
    for (int unsigned j = 0; j < N; j++) begin
      bit_idx = IDX_W'(j * N) + IDX_W'(k_idx);
`ifdef PAGERANK_SELF_LOOP_MASK_EN
      if (K_W'(j) != k_idx) begin
        deg = deg + DEG_W'(adj_copy[bit_idx]);
      end
`else
      deg = deg + DEG_W'(adj_copy[bit_idx]);
`endif
    end
  end

  // Restoring division of 2^WIDTH by deg, using a divisor pre-shifted to the current quotient bit.
  always_comb begin
    trial      = rem - dsh;
    trial_ok   = (rem >= dsh);
    quot_final = {quot[WIDTH-2:0], trial_ok};
    last_iter  = (iter == IT_W'(WIDTH - 1));
    last_node  = (k_idx == K_W'(N - 1));
    if (divisor == '0) begin
      weight_k = '0;
    end else if (divisor == DEG_W'(1)) begin
      weight_k = '1;
    end else begin
      weight_k = quot_final;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_DEG;
        end
      end
      S_DEG: begin
        busy       = 1'b1;
        state_next = S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = last_node ? S_DONE : S_DEG;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      adj_copy      <= '0;
      k_idx         <= '0;
      iter          <= '0;
      divisor       <= '0;
      rem           <= '0;
      dsh           <= '0;
      quot          <= '0;
      dangling      <= '0;
      weights_valid <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        w_arr[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            adj_copy      <= adjacency;
            weights_valid <= 1'b0;
            k_idx         <= '0;
          end
        end
        S_DEG: begin
          divisor <= deg;
          rem     <= REM_W'(1) << WIDTH;
          dsh     <= REM_W'(deg) << (WIDTH - 1);
          quot    <= '0;
          iter    <= '0;
        end
        S_DIV: begin
          if (trial_ok) begin
            rem <= trial;
          end
          dsh  <= dsh >> 1;
          quot <= quot_final;
          iter <= iter + IT_W'(1);
          if (last_iter) begin
            w_arr[k_idx]    <= weight_k;
            dangling[k_idx] <= (divisor == '0);
            if (last_node) begin
              weights_valid <= 1'b1;
            end else begin
              k_idx <= k_idx + K_W'(1);
            end
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign weights[g*WIDTH +: WIDTH] = w_arr[g];
  end

endmodule
